// File: rtl/alu_seq_addsub.sv
// Digit-serial add/subtract/compare: one K-bit digit per clock, LSB digit first.
// States: IDLE waits for start | RUN processes a digit per cycle | DONE holds the one-cycle done pulse.
module alu_seq_addsub #(
    parameter int N = 8,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         reset_p,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         carry,
    output logic         overflow,
    output logic         equal,
    output logic         greater,
    output logic         less
);

    localparam int ND = N / K;
    localparam int CW = (ND > 1) ? $clog2(ND) : 1;
    localparam logic [CW-1:0] LAST = CW'(ND - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [N-1:0]   a_q;
    logic [N-1:0]   b_q;
    logic [N-1:0]   acc;
    logic           sub_q;
    logic           cmp_q;
    logic           c_q;
    logic [CW-1:0]  cnt;

    logic [K-1:0]   b_dig;
    logic [K:0]     dsum;
    logic [N+K-1:0] acc_cat;
    logic [N-1:0]   diff;
    logic           cout;
    logic           msb_cin;

    always_comb begin
        b_dig   = b_q[K-1:0] ^ {K{sub_q}};
        dsum    = {1'b0, a_q[K-1:0]} + {1'b0, b_dig} + {{K{1'b0}}, c_q};
        // New digit enters at the top; after ND digits the word is fully aligned.
        acc_cat = {dsum[K-1:0], acc};
        diff    = acc_cat[N+K-1:K];
        cout    = dsum[K];
        // Only meaningful on the final digit, where bit K-1 is the operand MSB.
        msb_cin = dsum[K-1] ^ a_q[K-1] ^ b_dig[K-1];
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
            sub_q    <= 1'b0;
            cmp_q    <= 1'b0;
            c_q      <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            equal    <= 1'b0;
            greater  <= 1'b0;
            less     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        sub_q <= (op == 2'b01) || (op == 2'b10);
                        cmp_q <= (op == 2'b10);
                        c_q   <= (op == 2'b01) || (op == 2'b10);
                        cnt   <= LAST;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_q <= a_q >> K;
                    b_q <= b_q >> K;
                    acc <= diff;
                    c_q <= cout;
                    if (cnt == '0) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        if (!cmp_q) begin
                            result <= diff;
                        end
                        carry    <= cout;
                        overflow <= msb_cin ^ cout;
                        equal    <= sub_q & (diff == '0);
                        less     <= sub_q & ~cout;
                        greater  <= sub_q & cout & (diff != '0);
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_addsub.sv
// Bench for alu_seq_addsub: three builds (8/4, 16/1, 8/8) against an arithmetic reference model.
module tb_alu_seq_addsub;

    logic clk = 1'b0;
    logic reset_p;
    always #5 clk = ~clk;

    logic        s0, s1, s2;
    logic [1:0]  o0, o1, o2;
    logic [7:0]  a0, b0, a2, b2;
    logic [15:0] a1, b1;
    logic        busy0, busy1, busy2, done0, done1, done2;
    logic [7:0]  r0, r2;
    logic [15:0] r1;
    logic        c0, c1, c2, v0, v1, v2;
    logic        e0, e1, e2, g0, g1, g2, l0, l1, l2;

    int     n_vec = 0;
    int     n_err = 0;
    longint exp_res[3];

    alu_seq_addsub #(.N(8), .K(4)) dut0 (
        .clk(clk), .reset_p(reset_p), .start(s0), .op(o0), .a(a0), .b(b0),
        .busy(busy0), .done(done0), .result(r0), .carry(c0), .overflow(v0),
        .equal(e0), .greater(g0), .less(l0));

    alu_seq_addsub #(.N(16), .K(1)) dut1 (
        .clk(clk), .reset_p(reset_p), .start(s1), .op(o1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .result(r1), .carry(c1), .overflow(v1),
        .equal(e1), .greater(g1), .less(l1));

    alu_seq_addsub #(.N(8), .K(8)) dut2 (
        .clk(clk), .reset_p(reset_p), .start(s2), .op(o2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .result(r2), .carry(c2), .overflow(v2),
        .equal(e2), .greater(g2), .less(l2));

    function automatic int nd(input int d);
        return (d == 0) ? 2 : (d == 1) ? 16 : 1;
    endfunction

    function automatic int width(input int d);
        return (d == 1) ? 16 : 8;
    endfunction

    // Plain-arithmetic reference: value of the operation, not of any digit pipeline.
    function automatic void model(input int n, input logic [1:0] op, input longint a_in,
                                  input longint b_in, inout longint res,
                                  output logic c, output logic v, output logic e,
                                  output logic g, output logic l);
        longint m    = (longint'(1) << n) - 1;
        longint half = longint'(1) << (n - 1);
        longint a    = a_in & m;
        longint b    = b_in & m;
        longint sa   = (a >= half) ? a - (m + 1) : a;
        longint sb   = (b >= half) ? b - (m + 1) : b;
        longint r;
        longint s;
        if (op == 2'b01 || op == 2'b10) begin
            r = (a - b) & m;
            c = (a >= b);
            s = sa - sb;
            e = (a == b);
            g = (a > b);
            l = (a < b);
        end else begin
            r = (a + b) & m;
            c = ((a + b) > m);
            s = sa + sb;
            e = 1'b0;
            g = 1'b0;
            l = 1'b0;
        end
        v = (s >= half) || (s < -half);
        if (op != 2'b10) res = r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int d, input logic s, input logic [1:0] op,
                         input logic [15:0] a, input logic [15:0] b);
        case (d)
            0: begin s0 = s; o0 = op; a0 = a[7:0]; b0 = b[7:0]; end
            1: begin s1 = s; o1 = op; a1 = a; b1 = b; end
            default: begin s2 = s; o2 = op; a2 = a[7:0]; b2 = b[7:0]; end
        endcase
    endtask

    task automatic sample(input int d, output logic bz, output logic dn, output logic [15:0] r,
                          output logic c, output logic v, output logic e,
                          output logic g, output logic l);
        case (d)
            0: begin bz = busy0; dn = done0; r = {8'h00, r0}; c = c0; v = v0; e = e0; g = g0; l = l0; end
            1: begin bz = busy1; dn = done1; r = r1; c = c1; v = v1; e = e1; g = g1; l = l1; end
            default: begin bz = busy2; dn = done2; r = {8'h00, r2}; c = c2; v = v2; e = e2; g = g2; l = l2; end
        endcase
    endtask

    // Entered at the negedge just after the edge that sampled start.
    task automatic wait_done(input int d, input logic [1:0] op, input logic [15:0] a,
                             input logic [15:0] b, input string tag);
        int edges = 1;
        int busy_n = 0;
        logic bz, dn, c, v, e, g, l;
        logic [15:0] r;
        logic ec, ev, ee, eg, el;
        sample(d, bz, dn, r, c, v, e, g, l);
        while (!dn && edges < 64) begin
            if (bz) busy_n++;
            @(negedge clk);
            edges++;
            sample(d, bz, dn, r, c, v, e, g, l);
        end
        model(width(d), op, longint'(a), longint'(b), exp_res[d], ec, ev, ee, eg, el);
        check({tag, " latency"}, edges, nd(d) + 1);
        check({tag, " busy cycles"}, busy_n, nd(d));
        check({tag, " busy at done"}, {31'd0, bz}, 32'd0);
        check({tag, " result"}, {16'd0, r}, 32'(exp_res[d]));
        check({tag, " carry"}, {31'd0, c}, {31'd0, ec});
        check({tag, " overflow"}, {31'd0, v}, {31'd0, ev});
        check({tag, " flags eq/gt/lt"}, {29'd0, e, g, l}, {29'd0, ee, eg, el});
    endtask

    // Entered at a negedge; start is sampled by the next rising edge.
    task automatic run(input int d, input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] b, input string tag);
        logic bz, dn, c, v, e, g, l;
        logic [15:0] r;
        drive(d, 1'b1, op, a, b);
        @(negedge clk);
        drive(d, 1'b0, 2'($urandom), 16'($urandom), 16'($urandom));
        sample(d, bz, dn, r, c, v, e, g, l);
        check({tag, " busy/done in run"}, {30'd0, bz, dn}, 32'd2);
        wait_done(d, op, a, b, tag);
    endtask

    initial begin
        logic bz, dn, c, v, e, g, l, seen;
        logic [15:0] r;
        reset_p = 1'b1;
        for (int d = 0; d < 3; d++) begin
            drive(d, 1'b0, 2'b00, 16'h0000, 16'h0000);
            exp_res[d] = 0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            sample(d, bz, dn, r, c, v, e, g, l);
            check($sformatf("reset state dut%0d", d), {8'd0, bz, dn, r, c, v, e, g, l}, 32'd0);
        end
        reset_p = 1'b0;

        run(0, 2'b00, 16'hFF, 16'h01, "add ff+01");
        run(0, 2'b00, 16'h7F, 16'h01, "add 7f+01");
        run(0, 2'b01, 16'h80, 16'h01, "sub 80-01");
        run(0, 2'b01, 16'h05, 16'h07, "sub 05-07");
        run(0, 2'b10, 16'h3C, 16'h3C, "cmp 3c-3c");
        run(0, 2'b11, 16'hC0, 16'h50, "reserved c0+50");
        @(negedge clk);

        // Start pulses during RUN must be ignored; start in DONE launches at once.
        drive(0, 1'b1, 2'b00, 16'h11, 16'h22);
        @(negedge clk);
        drive(0, 1'b1, 2'b01, 16'h99, 16'h99);
        @(negedge clk);
        drive(0, 1'b1, 2'b00, 16'h77, 16'h01);
        @(negedge clk);
        sample(0, bz, dn, r, c, v, e, g, l);
        check("ignored start done", {31'd0, dn}, 32'd1);
        check("ignored start result", {16'd0, r}, 32'h33);
        exp_res[0] = 'h33;
        drive(0, 1'b1, 2'b01, 16'h50, 16'h20);
        @(negedge clk);
        drive(0, 1'b0, 2'b00, 16'h00, 16'h00);
        wait_done(0, 2'b01, 16'h50, 16'h20, "back-to-back sub");

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(1, 0) == 1) @(negedge clk);
            run(0, 2'($urandom_range(3, 0)), 16'($urandom), 16'($urandom), $sformatf("rand8 #%0d", i));
        end

        run(1, 2'b00, 16'hFFFF, 16'h0001, "n16 add ffff+0001");
        for (int i = 0; i < 4; i++)
            run(1, 2'($urandom_range(3, 0)), 16'($urandom), 16'($urandom), $sformatf("rand16 #%0d", i));

        run(2, 2'b00, 16'hFF, 16'h01, "k8 add ff+01");
        for (int i = 0; i < 10; i++)
            run(2, 2'($urandom_range(3, 0)), 16'($urandom), 16'($urandom), $sformatf("randk8 #%0d", i));

        // Reset in the second RUN cycle discards the operation.
        run(0, 2'b00, 16'h12, 16'h34, "pre-reset add");
        drive(0, 1'b1, 2'b00, 16'h55, 16'h11);
        @(negedge clk);
        drive(0, 1'b0, 2'b00, 16'h00, 16'h00);
        @(negedge clk);
        #2 reset_p = 1'b1;
        #1 sample(0, bz, dn, r, c, v, e, g, l);
        check("async reset clears", {8'd0, bz, dn, r, c, v, e, g, l}, 32'd0);
        for (int d = 0; d < 3; d++) exp_res[d] = 0;
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            sample(0, bz, dn, r, c, v, e, g, l);
            seen = seen | dn;
        end
        reset_p = 1'b0;
        repeat (4) begin
            @(negedge clk);
            sample(0, bz, dn, r, c, v, e, g, l);
            seen = seen | dn | bz;
        end
        check("no done after reset", {31'd0, seen}, 32'd0);
        run(0, 2'b00, 16'h10, 16'h20, "post-reset add 10+20");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq_addsub.md
ALU_SEQ_ADDSUB -- requirements
Module: alu_seq_addsub

Interface
REQ-001 SHALL provide parameter N, default 8, operand/result width in bits; legal N >= 2.
REQ-002 SHALL provide parameter K, default 4, digit width processed per clock; legal 1 <= K <= N, N divisible by K.
REQ-003 SHALL provide port clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 SHALL provide port reset_p  input  1  reset, asynchronous and active-high.
REQ-005 SHALL provide port start  input  1  request; sampled only when busy=0.
REQ-006 SHALL provide port op  input  2  00 add, 01 sub, 10 compare (subtract, flags only), 11 reserved, executes as add.
REQ-007 SHALL provide port a  input  N  operand A, unsigned or two's complement.
REQ-008 SHALL provide port b  input  N  operand B.
REQ-009 SHALL provide port busy  output  1  high while an operation is in progress.
REQ-010 SHALL provide port done  output  1  single-cycle completion pulse.
REQ-011 SHALL provide port result  output  N  sum or difference.
REQ-012 SHALL provide port carry  output  1  carry-out; for sub/compare 1 = no borrow.
REQ-013 SHALL provide port overflow  output  1  two's-complement overflow of the operation.
REQ-014 SHALL provide ports equal, greater, less  output  1 each  unsigned A vs B relation.

Function
REQ-015 SHALL implement an FSM with states IDLE, RUN, DONE; busy=1 only in RUN, done=1 only in DONE.
REQ-016 SHALL, when start=1 in IDLE or DONE, latch a, b and op and enter RUN with digit index 0 and initial carry = 0 for add/reserved, 1 for sub/compare.
REQ-017 SHALL ignore start and any change on a, b, op while in RUN.
REQ-018 SHALL in each RUN cycle compute one K-bit digit, LSB digit first: {c, d} = a_digit + (b_digit XOR {K{sub}}) + c, where sub = 1 for op 01/10.
REQ-019 SHALL leave RUN for DONE after exactly N/K RUN cycles; DONE lasts one cycle, then IDLE unless a new start is accepted.
REQ-020 SHALL assert done N/K+1 rising edges after the edge that samples start, for exactly one cycle.
REQ-021 SHALL keep result, carry, overflow, equal, greater, less unchanged until the RUN-to-DONE edge, then update them all on that edge and hold them until the next completion.
REQ-022 SHALL set overflow = carry into MSB XOR carry out of MSB.
REQ-023 SHALL for op 10 leave result unchanged and update carry, overflow and flags.
REQ-024 SHALL for sub/compare set equal = (difference==0), less = ~carry, greater = carry & ~equal; exactly one flag high.
REQ-025 SHALL for add/reserved clear equal, greater and less to 0.
REQ-026 SHALL accept start in the DONE cycle: done pulses, operands are latched, and RUN follows with no idle gap.

Reset
REQ-027 SHALL, on reset_p=1 at any time including mid-RUN, immediately enter IDLE and drive busy, done, result, carry, overflow, equal, greater, less to 0; the in-flight operation is discarded.
REQ-028 SHALL after reset release accept a start on the first rising edge with reset_p=0.

Verification (N=8, K=4 unless stated)
REQ-029 SHALL verify add 0xFF+0x01: busy high 2 cycles, done on 3rd edge-cycle, result=0x00, carry=1, overflow=0, flags 000.
REQ-030 SHALL verify add 0x7F+0x01 -> result=0x80, carry=0, overflow=1; sub 0x80-0x01 -> result=0x7F, carry=1, overflow=1, greater=1.
REQ-031 SHALL verify sub 0x05-0x07 -> result=0xFE, carry=0, less=1; then compare 0x3C vs 0x3C -> result stays 0xFE, equal=1, carry=1.
REQ-032 SHALL verify start pulsed with new operands during RUN is ignored, and start in the DONE cycle launches a back-to-back operation whose done follows 3 cycles later.
REQ-033 SHALL verify reset_p asserted in the 2nd RUN cycle clears all outputs to 0 asynchronously, no done pulse occurs, and a following add 0x10+0x20 yields 0x30.
REQ-034 SHALL verify N=16,K=1 and N=8,K=8 builds: latency 17 and 2 edges respectively, result 0xFFFF+0x0001=0x0000 carry=1 for N=16.
